ff_bank_scheduler: RTL

//  Sequencer/arbiter for the shared bank of single-bit D flip-flop registers (sync-clear, posedge cells).

---
 rtl/ffbank_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/ff_bank_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ffbank_pkg.sv
// rtl/ffbank_pkg.sv - shared types, default sizes and one-hot helpers for the flip-flop bank scheduler
//
// Purpose : common definitions imported by rr_arbiter and ff_bank_scheduler.
// Contents: DEF_NREQ / DEF_NREG / DEF_DW default sizes, state_t (ST_IDLE, ST_CLEAR),
//           onehot32 (binary index -> one-hot), bin32 (one-hot -> binary index).
// Ports   : none (package).
package ffbank_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_NREG = 8;
   localparam int DEF_DW   = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Callers truncate the result to their own vector width with a size cast.
   function automatic logic [31:0] onehot32(input logic [31:0] idx);
      return 32'd1 << idx;
   endfunction

   // OR-reduction of set-bit positions; exact for a one-hot (or all-zero) input.
   function automatic logic [31:0] bin32(input logic [31:0] oh);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) b = b | 32'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker for the bank write port
//
// Purpose: starting at position ptr and wrapping modulo NREQ, picks the first
//          asserted request.
// Ports  : req       in  NREQ  request vector (already filtered by the caller)
//          ptr       in  IW    highest-priority requester index
//          gnt       out NREQ  one-hot pick, zero when no request
//          gnt_idx   out IW    binary index of the pick (0 when none)
//          gnt_valid out 1     a pick was made
module rr_arbiter
   import ffbank_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_valid
);

   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] cand;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      cand      = '0;
      // Walk priority positions ptr, ptr+1, ... with an explicit wrap, so
      // non-power-of-two NREQ works without a modulo operator.
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
         cand = sum[IW-1:0];
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
      gnt = gnt_valid ? NREQ'(onehot32(32'(gnt_idx))) : '0;
   end

endmodule

// File: rtl/ff_bank_scheduler.sv
// rtl/ff_bank_scheduler.sv - round-robin write-port sequencer and clear walker for the flip-flop bank
//
// Purpose: shares the register bank's single write port among NREQ requesters,
//          one write per cycle, and runs a walk that strobes every register's
//          sync clear in turn. Sole driver of the bank's d/load/clear inputs.
// Ports  : clk       in  1        rising-edge clock
//          rst       in  1        asynchronous active-low reset
//          req       in  NREQ     level write request per requester
//          req_addr  in  NREQ*AW  target register, requester i at [i*AW +: AW]
//          req_data  in  NREQ*DW  write data, requester i at [i*DW +: DW]
//          clr_all   in  1        start a clear walk (looked at in IDLE only)
//          gnt       out NREQ     one-hot, requester's write issued this cycle
//          bank_we   out NREG     one-hot load enable to the bank
//          bank_d    out DW       data to the bank while bank_we != 0
//          bank_clr  out NREG     one-hot sync-clear strobe to the bank
//          busy      out 1        a clear strobe is being shown
//          clr_done  out 1        pulse alongside the last clear strobe
//          addr_err  out 1        pulse: granted request addressed a missing register
module ff_bank_scheduler
   import ffbank_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int NREG = DEF_NREG,
   parameter int DW   = DEF_DW,
   parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic             clr_all,
   output logic [NREQ-1:0]  gnt,
   output logic [NREG-1:0]  bank_we,
   output logic [DW-1:0]    bank_d,
   output logic [NREG-1:0]  bank_clr,
   output logic             busy,
   output logic             clr_done,
   output logic             addr_err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
   localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   clr_idx_q, clr_idx_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREG-1:0] bank_we_q, bank_we_d;
   logic [DW-1:0]   bank_d_q, bank_d_d;
   logic [NREG-1:0] bank_clr_q, bank_clr_d;
   logic            busy_q, busy_d;
   logic            clr_done_q, clr_done_d;
   logic            addr_err_q, addr_err_d;

   logic [NREQ-1:0] req_eff;
   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   arb_idx;
   logic            arb_valid;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // A requester sees its grant one cycle late and may still be holding the
   // request it just had served; masking with the current grant stops a
   // second write of the same request.
   assign req_eff = req & ~gnt_q;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req       (req_eff),
      .ptr       (ptr_q),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   assign sel_addr = req_addr[int'(arb_idx)*AW +: AW];
   assign sel_data = req_data[int'(arb_idx)*DW +: DW];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clr_idx_d  = clr_idx_q;
      gnt_d      = '0;
      bank_we_d  = '0;
      bank_d_d   = '0;
      bank_clr_d = '0;
      busy_d     = 1'b0;
      clr_done_d = 1'b0;
      addr_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (clr_all) begin
               // Strobe register 0 straight away; clr_idx then holds the
               // next register to strobe, so the FSM is back in IDLE while
               // the final strobe is on the outputs and arbitration resumes
               // on the very next edge.
               busy_d     = 1'b1;
               bank_clr_d = NREG'(onehot32(32'd0));
               if (NREG == 1) begin
                  clr_done_d = 1'b1;
               end else begin
                  state_d   = ST_CLEAR;
                  clr_idx_d = AW'(1);
               end
            end else if (arb_valid) begin
               gnt_d = arb_gnt;
               ptr_d = (arb_idx == LAST_REQ) ? '0 : arb_idx + IW'(1);
               if ({1'b0, sel_addr} < NREG_W) begin
                  bank_we_d = NREG'(onehot32(32'(sel_addr)));
                  bank_d_d  = sel_data;
               end else begin
                  addr_err_d = 1'b1;
               end
            end
         end

         ST_CLEAR: begin
            busy_d     = 1'b1;
            bank_clr_d = NREG'(onehot32(32'(clr_idx_q)));
            if (clr_idx_q == LAST_IDX) begin
               clr_done_d = 1'b1;
               clr_idx_d  = '0;
               state_d    = ST_IDLE;
            end else begin
               clr_idx_d = clr_idx_q + AW'(1);
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clr_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         clr_idx_q  <= '0;
         gnt_q      <= '0;
         bank_we_q  <= '0;
         bank_d_q   <= '0;
         bank_clr_q <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         clr_idx_q  <= clr_idx_d;
         gnt_q      <= gnt_d;
         bank_we_q  <= bank_we_d;
         bank_d_q   <= bank_d_d;
         bank_clr_q <= bank_clr_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign gnt      = gnt_q;
   assign bank_we  = bank_we_q;
   assign bank_d   = bank_d_q;
   assign bank_clr = bank_clr_q;
   assign busy     = busy_q;
   assign clr_done = clr_done_q;
   assign addr_err = addr_err_q;

endmodule
